// File: rtl/sand_scanner.sv
// sand_scanner: frame sequencer for the sand-cell updater.
// Walks the grid bottom-up one row pair at a time. For every word column it
// reads the region word (row r) and the floor word (row r+1), holds them for
// the combinational updater, then writes both results back in place.
module sand_scanner #(
  parameter int unsigned WORDS_PER_ROW = 40,
  parameter int unsigned ROWS          = 480,
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned SPOUT_COL     = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              spout_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       upd_region,
  output logic [31:0]       upd_floor,
  output logic              upd_screenbegin,
  output logic              upd_screenend,
  output logic              upd_screenbottom,
  output logic              upd_spout,
  input  logic [31:0]       upd_new_region,
  input  logic [31:0]       upd_new_floor
);

  localparam int unsigned COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned ROW_W = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(WORDS_PER_ROW);
  // Base of the bottom-most row pair; computed at elaboration, no multiplier.
  localparam logic [ADDR_W-1:0] RBASE_FIRST = ADDR_W'((ROWS - 2) * WORDS_PER_ROW);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_FIRST   = ROW_W'(ROWS - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_R, S_RD_F, S_CAP, S_WR_R, S_WR_F, S_FIN
  } state_t;

  state_t            state_q;
  logic [ROW_W-1:0]  r_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] rbase_q;
  logic              spout_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       region_q;
  logic [31:0]       floor_q;

  // Address helpers derived from the running row base and column.
  logic [ADDR_W-1:0] addr_region;
  logic [ADDR_W-1:0] addr_floor;
  logic [ADDR_W-1:0] rbase_up_d;

  assign addr_region = rbase_q + ADDR_W'(col_q);
  assign addr_floor  = addr_region + ROW_STRIDE;
  assign rbase_up_d  = rbase_q - ROW_STRIDE;

  // Sequencer: state, row/column walk and registered memory strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      col_q    <= '0;
      rbase_q  <= '0;
      spout_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      region_q <= '0;
      floor_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            spout_q <= spout_en;
            r_q     <= ROW_FIRST;
            col_q   <= '0;
            rbase_q <= RBASE_FIRST;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= RBASE_FIRST;
            state_q <= S_RD_R;
          end
        end
        S_RD_R: begin
          addr_q  <= addr_floor;
          state_q <= S_RD_F;
        end
        S_RD_F: begin
          // Region word requested in RD_R arrives now.
          region_q <= mem_rdata;
          rd_q     <= 1'b0;
          addr_q   <= '0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          floor_q <= mem_rdata;
          wr_q    <= 1'b1;
          addr_q  <= addr_region;
          state_q <= S_WR_R;
        end
        S_WR_R: begin
          addr_q  <= addr_floor;
          state_q <= S_WR_F;
        end
        S_WR_F: begin
          wr_q <= 1'b0;
          if (col_q < COL_LAST) begin
            col_q   <= col_q + 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= addr_region + 1'b1;
            state_q <= S_RD_R;
          end else if (r_q != '0) begin
            col_q   <= '0;
            r_q     <= r_q - 1'b1;
            rbase_q <= rbase_up_d;
            rd_q    <= 1'b1;
            addr_q  <= rbase_up_d;
            state_q <= S_RD_R;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= '0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write data comes straight from the combinational updater.
  always_comb begin
    mem_wdata = '0;
    if (state_q == S_WR_R) begin
      mem_wdata = upd_new_region;
    end else if (state_q == S_WR_F) begin
      mem_wdata = upd_new_floor;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign upd_region = region_q;
  assign upd_floor  = floor_q;

  assign upd_screenbegin  = (col_q == '0);
  assign upd_screenend    = (col_q == COL_LAST);
  assign upd_screenbottom = (r_q == ROW_FIRST);
  assign upd_spout        = spout_q && (r_q == '0) && (32'(col_q) == SPOUT_COL);

endmodule
